// File: rtl/door_pkg.sv
// Shared types and constants for the elevator door controller and its timer.
package door_pkg;

  typedef enum logic [1:0] {
    StClosed  = 2'd0,
    StOpen    = 2'd1,
    StClosing = 2'd2,
    StAlarm   = 2'd3
  } door_state_e;

  localparam int DefOpenTime  = 10;
  localparam int DefCloseTime = 4;

  // Timer holds at most max(open, close) - 1; never narrower than one bit.
  function automatic int unsigned timer_width(input int open_time, input int close_time);
    int max_time;
    max_time = (open_time > close_time) ? open_time : close_time;
    return ($clog2(max_time) < 1) ? 1 : $clog2(max_time);
  endfunction

endpackage

// File: rtl/door_timer.sv
// Loadable down-counter with enable and zero flag; saturates at zero.
module door_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  input  logic             enable_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_value_i;
    end else if (enable_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/door_controller.sv
// Elevator car door FSM: open/close timing, overload alarm and weight-counter clear handshake.
module door_controller
  import door_pkg::*;
#(
  parameter int OPEN_TIME  = DefOpenTime,
  parameter int CLOSE_TIME = DefCloseTime
) (
  input  logic clk,
  input  logic reset,
  input  logic open_request,
  input  logic car_empty,
  input  logic alarm_clear,
  input  logic weight_limit_exceeded,
  output logic door,
  output logic weight_flip_reset,
  output logic overload_alarm,
  output logic door_ready
);

  if (OPEN_TIME < 1 || CLOSE_TIME < 1) begin : g_bad_timing
    $error("door_controller: OPEN_TIME and CLOSE_TIME must both be >= 1");
  end

  localparam int unsigned TimerW = timer_width(OPEN_TIME, CLOSE_TIME);
  localparam logic [TimerW-1:0] OpenLoad  = TimerW'(OPEN_TIME - 1);
  localparam logic [TimerW-1:0] CloseLoad = TimerW'(CLOSE_TIME - 1);

  door_state_e state_q, state_d;
  logic sync1_q, sync2_q, wle_s;
  logic timer_load, timer_enable, timer_zero;
  logic [TimerW-1:0] timer_value;
  logic flip_req, flip_d, flip_q;
  logic empty_done_d, empty_done_q;
  logic door_d, door_q, ready_d, ready_q, alarm_d, alarm_q;

  assign wle_s = sync2_q;

  // State register and input synchroniser.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StClosed;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= weight_limit_exceeded;
      sync2_q <= sync1_q;
    end
  end

  // Next state, timer control and clear-pulse request.
  always_comb begin
    state_d      = state_q;
    timer_load   = 1'b0;
    timer_enable = 1'b0;
    timer_value  = OpenLoad;
    flip_req     = 1'b0;
    unique case (state_q)
      StClosed: begin
        if (open_request) begin
          state_d    = StOpen;
          timer_load = 1'b1;
        end else if (car_empty && !empty_done_q) begin
          flip_req = 1'b1;
        end
      end
      StOpen: begin
        if (wle_s) begin
          state_d = StAlarm;
        end else if (open_request) begin
          timer_load = 1'b1;
        end else if (timer_zero) begin
          state_d     = StClosing;
          timer_load  = 1'b1;
          timer_value = CloseLoad;
        end else begin
          timer_enable = 1'b1;
        end
      end
      StAlarm: begin
        // The counter is cleared here; a persisting overload re-alarms via StOpen.
        if (alarm_clear) begin
          state_d    = StOpen;
          timer_load = 1'b1;
          flip_req   = 1'b1;
        end
      end
      StClosing: begin
        if (open_request || wle_s) begin
          state_d    = StOpen;
          timer_load = 1'b1;
        end else if (timer_zero) begin
          state_d = StClosed;
        end else begin
          timer_enable = 1'b1;
        end
      end
    endcase
  end

  // Outputs decoded from the next state so the registered copies track state_q exactly.
  always_comb begin
    door_d  = (state_d == StOpen) || (state_d == StAlarm);
    ready_d = (state_d == StClosed);
    alarm_d = (state_d == StAlarm);
    flip_d  = flip_req && !flip_q;
    // Any clear pulse while car_empty is high satisfies the unload request.
    if (!car_empty) begin
      empty_done_d = 1'b0;
    end else if (flip_d) begin
      empty_done_d = 1'b1;
    end else begin
      empty_done_d = empty_done_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      door_q       <= 1'b0;
      ready_q      <= 1'b1;
      alarm_q      <= 1'b0;
      flip_q       <= 1'b1;
      empty_done_q <= 1'b1;
    end else begin
      door_q       <= door_d;
      ready_q      <= ready_d;
      alarm_q      <= alarm_d;
      flip_q       <= flip_d;
      empty_done_q <= empty_done_d;
    end
  end

  door_timer #(
    .WIDTH (TimerW)
  ) u_timer (
    .clk_i        (clk),
    .reset_i      (reset),
    .load_i       (timer_load),
    .load_value_i (timer_value),
    .enable_i     (timer_enable),
    .zero_o       (timer_zero)
  );

  assign door              = door_q;
  assign door_ready        = ready_q;
  assign overload_alarm    = alarm_q;
  assign weight_flip_reset = flip_q;

endmodule

// File: tb/tb_door_controller.sv
// Directed bench for door_controller with OPEN_TIME=4, CLOSE_TIME=2.
module tb_door_controller;

  logic clk = 1'b0;
  logic reset, open_request, car_empty, alarm_clear, weight_limit_exceeded;
  logic door, weight_flip_reset, overload_alarm, door_ready;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  door_controller #(
    .OPEN_TIME  (4),
    .CLOSE_TIME (2)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .open_request          (open_request),
    .car_empty             (car_empty),
    .alarm_clear           (alarm_clear),
    .weight_limit_exceeded (weight_limit_exceeded),
    .door                  (door),
    .weight_flip_reset     (weight_flip_reset),
    .overload_alarm        (overload_alarm),
    .door_ready            (door_ready)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    total++;
    if ({weight_flip_reset, door, door_ready, overload_alarm} !== 4'b1010) begin
      bad++;
      $display("FAIL reset_state: flip/door/ready/alarm=%b want 1010",
               {weight_flip_reset, door, door_ready, overload_alarm});
    end
    reset = 1'b0;
    tick();
    total++;
    if ({weight_flip_reset, door, door_ready, overload_alarm} !== 4'b0010) begin
      bad++;
      $display("FAIL reset_release: flip/door/ready/alarm=%b want 0010",
               {weight_flip_reset, door, door_ready, overload_alarm});
    end
  endtask

  task automatic test_normal();
    open_request = 1'b1;
    tick();
    open_request = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({door, door_ready} !== 2'b10) begin
        bad++;
        $display("FAIL normal_open[%0d]: door/ready=%b want 10", i, {door, door_ready});
      end
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      total++;
      if ({door, door_ready} !== 2'b00) begin
        bad++;
        $display("FAIL normal_closing[%0d]: door/ready=%b want 00", i, {door, door_ready});
      end
      tick();
    end
    total++;
    if ({door, door_ready} !== 2'b01) begin
      bad++;
      $display("FAIL normal_closed: door/ready=%b want 01", {door, door_ready});
    end
  endtask

  task automatic test_reopen();
    open_request = 1'b1;
    tick();
    open_request = 1'b0;
    repeat (4) tick();
    total++;
    if ({door, door_ready} !== 2'b00) begin
      bad++;
      $display("FAIL reopen_closing: door/ready=%b want 00", {door, door_ready});
    end
    open_request = 1'b1;
    tick();
    open_request = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (door !== 1'b1) begin
        bad++;
        $display("FAIL reopen_window[%0d]: door=%b want 1", i, door);
      end
      tick();
    end
    total++;
    if (door !== 1'b0) begin
      bad++;
      $display("FAIL reopen_end: door=%b want 0", door);
    end
    repeat (2) tick();
    total++;
    if (door_ready !== 1'b1) begin
      bad++;
      $display("FAIL reopen_ready: door_ready=%b want 1", door_ready);
    end
  endtask

  task automatic test_overload();
    open_request = 1'b1;
    tick();
    open_request = 1'b0;
    weight_limit_exceeded = 1'b1;
    repeat (3) tick();
    total++;
    if ({overload_alarm, door} !== 2'b11) begin
      bad++;
      $display("FAIL overload_alarm: alarm/door=%b want 11", {overload_alarm, door});
    end
    for (int i = 0; i < 8; i++) begin
      open_request = i[0];
      tick();
      total++;
      if ({overload_alarm, door, door_ready} !== 3'b110) begin
        bad++;
        $display("FAIL overload_hold[%0d]: alarm/door/ready=%b want 110", i,
                 {overload_alarm, door, door_ready});
      end
    end
    open_request = 1'b0;
    weight_limit_exceeded = 1'b0;
    repeat (3) tick();
    total++;
    if (overload_alarm !== 1'b1) begin
      bad++;
      $display("FAIL overload_needs_clear: alarm=%b want 1", overload_alarm);
    end
    alarm_clear = 1'b1;
    tick();
    alarm_clear = 1'b0;
    total++;
    if ({weight_flip_reset, overload_alarm, door} !== 3'b101) begin
      bad++;
      $display("FAIL overload_clear: flip/alarm/door=%b want 101",
               {weight_flip_reset, overload_alarm, door});
    end
    for (int i = 1; i < 4; i++) begin
      tick();
      total++;
      if ({weight_flip_reset, overload_alarm, door} !== 3'b001) begin
        bad++;
        $display("FAIL overload_after[%0d]: flip/alarm/door=%b want 001", i,
                 {weight_flip_reset, overload_alarm, door});
      end
    end
    tick();
    total++;
    if (door !== 1'b0) begin
      bad++;
      $display("FAIL overload_close: door=%b want 0", door);
    end
    repeat (2) tick();
    total++;
    if (door_ready !== 1'b1) begin
      bad++;
      $display("FAIL overload_ready: door_ready=%b want 1", door_ready);
    end
  endtask

  task automatic test_unload();
    int pulses = 0;
    int moved = 0;
    car_empty = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (weight_flip_reset === 1'b1) pulses++;
      if ({door, door_ready} !== 2'b01) moved++;
    end
    car_empty = 1'b0;
    tick();
    total++;
    if (pulses !== 1) begin
      bad++;
      $display("FAIL unload_pulses: got %0d want 1", pulses);
    end
    total++;
    if (moved !== 0) begin
      bad++;
      $display("FAIL unload_door: %0d moving cycles want 0", moved);
    end
  endtask

  task automatic test_clear_outside_alarm();
    alarm_clear = 1'b1;
    tick();
    alarm_clear = 1'b0;
    total++;
    if ({weight_flip_reset, door, door_ready} !== 3'b001) begin
      bad++;
      $display("FAIL clear_in_closed: flip/door/ready=%b want 001",
               {weight_flip_reset, door, door_ready});
    end
  endtask

  task automatic test_reset_mid();
    open_request = 1'b1;
    tick();
    open_request = 1'b0;
    weight_limit_exceeded = 1'b1;
    repeat (3) tick();
    total++;
    if (overload_alarm !== 1'b1) begin
      bad++;
      $display("FAIL midreset_setup: alarm=%b want 1", overload_alarm);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    weight_limit_exceeded = 1'b0;
    total++;
    if ({door, overload_alarm, door_ready, weight_flip_reset} !== 4'b0011) begin
      bad++;
      $display("FAIL midreset_state: door/alarm/ready/flip=%b want 0011",
               {door, overload_alarm, door_ready, weight_flip_reset});
    end
    tick();
    total++;
    if ({door, overload_alarm, door_ready, weight_flip_reset} !== 4'b0010) begin
      bad++;
      $display("FAIL midreset_after: door/alarm/ready/flip=%b want 0010",
               {door, overload_alarm, door_ready, weight_flip_reset});
    end
  endtask

  initial begin
    reset = 1'b1;
    open_request = 1'b0;
    car_empty = 1'b0;
    alarm_clear = 1'b0;
    weight_limit_exceeded = 1'b0;
    test_reset();
    test_normal();
    test_reopen();
    test_overload();
    test_unload();
    test_clear_outside_alarm();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, want finish");
    $fatal(1);
  end

endmodule

// File: doc/door_controller.md
Name: door_controller

Overview:
- Drives the elevator car door and handles the door/overload handshake with the weight-counter block.
- Produces `door`, which gates passenger-flip counting in the weight counter.
- Produces `weight_flip_reset`, which clears that counter.
- Consumes `weight_limit_exceeded` and holds the door open with an alarm while the car is overloaded.
- Sits between the floor/motion controller and the weight counter; grants motion only when the door is fully closed.

Parameters:
- OPEN_TIME, 10, cycles the door stays open with no further request.
- CLOSE_TIME, 4, cycles the closing travel takes; the door can still reopen during this time.

Ports:
- clk  input  1  system clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- open_request  input  1  level; car stopped at floor or open button pressed.
- car_empty  input  1  level; car unloaded (ground floor); requests a weight-counter clear.
- alarm_clear  input  1  level; operator/passenger acknowledges the overload has been removed.
- weight_limit_exceeded  input  1  from the weight counter; treated as asynchronous, double-flop synchronised internally.
- door  output  1  1 = door open; registered, glitch-free.
- weight_flip_reset  output  1  registered one-cycle clear pulse to the weight counter.
- overload_alarm  output  1  1 while in ALARM.
- door_ready  output  1  1 = door closed, motion permitted.

Behaviour:
- Reset: one clock; reset is synchronous and active-high.
  - After reset: state=CLOSED, timer=0, door=0, overload_alarm=0, door_ready=1, synchroniser flops=0.
  - weight_flip_reset=1 in the cycle following a sampled reset, then 0. This guarantees the weight counter is cleared at boot.
  - Reset mid-operation (any state) behaves identically.
- `wle_s` denotes synchronised weight_limit_exceeded, with 2 cycles of latency.
- Priority each cycle: reset > wle_s > alarm_clear > open_request > timer expiry.
- States:
  - CLOSED
    - door=0, door_ready=1.
    - open_request -> OPEN; timer<=OPEN_TIME-1.
    - Otherwise, car_empty=1 -> pulse weight_flip_reset (at most one pulse per rising edge of car_empty).
  - OPEN
    - door=1, door_ready=0.
    - wle_s -> ALARM.
    - open_request -> reload timer to OPEN_TIME-1.
    - timer==0 -> CLOSING; timer<=CLOSE_TIME-1.
    - Otherwise, timer decrements by 1.
  - ALARM
    - door=1, overload_alarm=1, timer frozen.
    - alarm_clear -> pulse weight_flip_reset, go to OPEN, timer<=OPEN_TIME-1.
    - open_request is ignored.
    - If wle_s is still 1 after the clear pulse has propagated, the FSM re-enters ALARM through OPEN. This is normal, not an error.
  - CLOSING
    - door=0, door_ready=0.
    - open_request or wle_s -> OPEN with timer<=OPEN_TIME-1 (reopen). wle_s goes to OPEN first, then ALARM on the next cycle.
    - timer==0 -> CLOSED.
    - Otherwise, timer decrements by 1.
- Outputs are decoded from the state register and are registered (Moore).
  - door changes exactly one cycle after the transition condition is sampled.
- Timer width = clog2(max(OPEN_TIME, CLOSE_TIME)); no wrap-around, since decrement only occurs while timer>0.
- weight_flip_reset is never asserted for 2 consecutive cycles.
  - A car_empty edge and alarm_clear in the same cycle produce a single pulse.
- alarm_clear outside ALARM has no effect.
- OPEN_TIME and CLOSE_TIME must be >=1; enforce this with an elaboration-time check.

Decomposition:
- Shared package `door_pkg`:
  - state encoding: CLOSED=2'd0, OPEN=2'd1, CLOSING=2'd2, ALARM=2'd3;
  - default timing constants.
- One sub-module, `door_timer`: loadable down-counter with load, enable and zero flag, parameterised width. Instantiated once.
- The 2-flop synchroniser stays inline.

Test Plan:
- All tests use OPEN_TIME=4, CLOSE_TIME=2.
- Reset release: reset=1 for 2 cycles, then 0 -> weight_flip_reset=1 for exactly 1 cycle; door=0; door_ready=1; state CLOSED.
- Normal cycle: 1-cycle open_request pulse -> door=1 next cycle and held 4 cycles, then door=0 and door_ready=0 for 2 cycles, then door_ready=1.
- Reopen: open_request asserted in the 1st CLOSING cycle -> door=1 next cycle; open window restarts at a full 4 cycles.
- Overload:
  - weight_limit_exceeded=1 in OPEN -> overload_alarm=1 within 3 cycles; door stays 1 indefinitely, including with open_request toggling.
  - alarm_clear=1 -> one weight_flip_reset pulse, overload_alarm=0, door stays 1 for 4 more cycles.
- Unload: in CLOSED, car_empty held high for 10 cycles -> exactly one weight_flip_reset pulse; no door movement.
- Mid-operation reset: assert reset in ALARM -> next cycle door=0, overload_alarm=0, door_ready=1, weight_flip_reset=1 for one cycle.
